// File: rtl/mpadder_arb_pkg.sv
// Shared constants for the multi-precision adder arbiter.
// State encoding and default widths.
package mpadder_arb_pkg;

  localparam int WIDTH_DEFAULT = 1027;
  localparam int RSP_WIDTH = WIDTH_DEFAULT + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

endpackage

// File: rtl/mpadder_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1,
// wrapping modulo NREQ; returns one-hot grant and its index.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int LW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic [LW-1:0]   idx
);

  logic [LW-1:0] cand;

  // walk from farthest to nearest so the nearest set bit wins
  always_comb begin
    grant = '0;
    idx = '0;
    cand = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = LW'((int'(last) + i) % NREQ);
      if (req[cand]) begin
        grant = '0;
        grant[cand] = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mpadder_arbiter.sv
// Shares one multi-precision add/sub unit among NREQ requesters.
// Optional adder_done watchdog: define MPADDER_ARB_TIMEOUT_EN.
module mpadder_arbiter
  import mpadder_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_subtract,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH:0]        rsp_result,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  adder_start,
  output logic                  adder_subtract,
  output logic [WIDTH-1:0]      adder_a,
  output logic [WIDTH-1:0]      adder_b,
  input  logic [WIDTH:0]        adder_result,
  input  logic                  adder_done
);

  localparam int LW = $clog2(NREQ);

  logic [1:0]      state;
  logic [LW-1:0]   last;
  logic [NREQ-1:0] grant;
  logic [LW-1:0]   gidx;
  logic            tmo;

  rr_arbiter #(
    .NREQ(NREQ),
    .LW(LW)
  ) u_rr (
    .req(req),
    .last(last),
    .grant(grant),
    .idx(gidx)
  );

  assign req_ready = (state == S_IDLE) ? grant : '0;
  assign busy = (state != S_IDLE);
  assign adder_start = (state == S_START);

  always_comb begin
    rsp_valid = '0;
    if (state == S_RESP) rsp_valid[last] = 1'b1;
  end

`ifdef MPADDER_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign tmo = (state == S_WAIT) && !adder_done
            && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!resetn || state != S_WAIT) cnt <= '0;
    else cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) timeout_err <= 1'b0;
    else if (tmo) timeout_err <= 1'b1;
  end
`else
  // watchdog compiled out; WAIT holds until adder_done
  assign tmo = (TIMEOUT < 0);
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      last <= LW'(NREQ - 1);
      adder_a <= '0;
      adder_b <= '0;
      adder_subtract <= 1'b0;
      rsp_result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            adder_a <= req_a[gidx*WIDTH +: WIDTH];
            adder_b <= req_b[gidx*WIDTH +: WIDTH];
            adder_subtract <= req_subtract[gidx];
            last <= gidx;
            state <= S_START;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (adder_done) begin
            rsp_result <= adder_result;
            state <= S_RESP;
          end else if (tmo) begin
            rsp_result <= '0;
            state <= S_RESP;
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpadder_arbiter.sv
// Scoreboard bench for mpadder_arbiter with a 4-cycle adder model.
// Timeout case runs when MPADDER_ARB_TIMEOUT_EN is defined.
module tb_mpadder_arbiter;

  localparam int W = 1027;
  localparam int RW = W + 1;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [1:0]      req = '0;
  logic [1:0]      req_subtract = '0;
  logic [2*W-1:0]  req_a = '0;
  logic [2*W-1:0]  req_b = '0;
  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;
  logic [RW-1:0]   rsp_result;
  logic            busy;
  logic            timeout_err;
  logic            adder_start;
  logic            adder_subtract;
  logic [W-1:0]    adder_a;
  logic [W-1:0]    adder_b;
  logic [RW-1:0]   adder_result;
  logic            adder_done;

  mpadder_arbiter #(.NREQ(2), .WIDTH(W), .TIMEOUT(64)) dut (
    .clk(clk),
    .resetn(resetn),
    .req(req),
    .req_subtract(req_subtract),
    .req_a(req_a),
    .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_result(rsp_result),
    .busy(busy),
    .timeout_err(timeout_err),
    .adder_start(adder_start),
    .adder_subtract(adder_subtract),
    .adder_a(adder_a),
    .adder_b(adder_b),
    .adder_result(adder_result),
    .adder_done(adder_done)
  );

  always #5 clk = ~clk;

  // adder model: done four cycles after the start pulse
  logic [3:0] sr;
  logic       stub = 1'b0;
  logic       spur = 1'b0;

  always @(posedge clk) begin
    if (!resetn) sr <= '0;
    else sr <= {sr[2:0], adder_start};
  end

  assign adder_done = (sr[3] & ~stub) | spur;
  assign adder_result = adder_subtract
    ? ({1'b0, adder_a} - {1'b0, adder_b})
    : ({1'b0, adder_a} + {1'b0, adder_b});

  int ncmp = 0;
  int nbad = 0;
  int cyc = 0;
  int n_ready = 0;
  int last_acc = 0;
  bit b2b = 1'b0;
  bit prev_ready = 1'b0;

  logic [1:0]    eg[$];
  logic [1:0]    ev[$];
  logic [RW-1:0] er[$];

  task automatic chk(input string nm, input logic [RW-1:0] act,
                     input logic [RW-1:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h_%016h want %0h_%016h", nm,
               act[RW-1], act[63:0], exp[RW-1], exp[63:0]);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a handshake
  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      prev_ready = 1'b0;
    end else begin
      if (adder_start) chk("start_after_ready", RW'(prev_ready), RW'(1));
      if (req_ready != 2'b00) begin
        n_ready++;
        if (eg.size() == 0) chk("unexpected_ready", RW'(req_ready), '0);
        else chk("grant", RW'(req_ready), RW'(eg.pop_front()));
        if (b2b) chk("accept_spacing", RW'(cyc - last_acc), RW'(7));
        last_acc = cyc;
      end
      if (rsp_valid != 2'b00) begin
        if (ev.size() == 0) begin
          chk("unexpected_rsp", RW'(rsp_valid), '0);
        end else begin
          chk("rsp_valid", RW'(rsp_valid), RW'(ev.pop_front()));
          chk("rsp_result", rsp_result, er.pop_front());
          if (!stub) chk("latency", RW'(cyc - last_acc), RW'(6));
        end
      end
      prev_ready = (req_ready != 2'b00);
    end
  end

  task automatic issue(input int idx, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic s,
                       input bit want, input logic [RW-1:0] res);
    int n;
    eg.push_back(2'b01 << idx);
    if (want) begin
      ev.push_back(2'b01 << idx);
      er.push_back(res);
    end
    @(posedge clk); #1;
    req[idx] = 1'b1;
    req_subtract[idx] = s;
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[idx] && n < 50);
    chk("ready_seen", RW'(req_ready[idx]), RW'(1));
    @(posedge clk); #1;
    req[idx] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (ev.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain", RW'(ev.size()), '0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ready(input int target);
    int n;
    n = 0;
    while (n_ready < target && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("ready_count", RW'(n_ready), RW'(target));
  endtask

  logic [RW-1:0] neg7;
  int base;

  initial begin
    neg7 = {1'b1, {1019{1'b1}}, 8'hF9};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", RW'(busy), '0);
    chk("rst_req_ready", RW'(req_ready), '0);
    chk("rst_rsp_valid", RW'(rsp_valid), '0);
    chk("rst_rsp_result", rsp_result, '0);
    chk("rst_adder_start", RW'(adder_start), '0);
    chk("rst_adder_a", RW'(adder_a), '0);
    chk("rst_adder_sub", RW'(adder_subtract), '0);
    chk("rst_timeout_err", RW'(timeout_err), '0);
    @(posedge clk); #1;
    resetn = 1'b1;

    issue(0, 5, 7, 1'b0, 1'b1, RW'(12));
    drain();
    issue(1, 10, 3, 1'b1, 1'b1, RW'(7));
    drain();
    issue(1, 3, 10, 1'b1, 1'b1, neg7);
    drain();
    chk("sub_borrow_bit", RW'(rsp_result[W]), RW'(1));

    eg.push_back(2'b01); ev.push_back(2'b01); er.push_back(RW'(101));
    eg.push_back(2'b10); ev.push_back(2'b10); er.push_back(RW'(30));
    eg.push_back(2'b01); ev.push_back(2'b01); er.push_back(RW'(101));
    eg.push_back(2'b10); ev.push_back(2'b10); er.push_back(RW'(30));
    base = n_ready;
    @(posedge clk); #1;
    req_a[0 +: W] = W'(100);
    req_b[0 +: W] = W'(1);
    req_subtract[0] = 1'b0;
    req_a[W +: W] = W'(50);
    req_b[W +: W] = W'(20);
    req_subtract[1] = 1'b1;
    req = 2'b11;
    wait_ready(base + 1);
    b2b = 1'b1;
    wait_ready(base + 4);
    @(posedge clk); #1;
    req = 2'b00;
    b2b = 1'b0;
    drain();

    @(posedge clk); #1;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    chk("spur_busy", RW'(busy), '0);
    chk("spur_rsp_valid", RW'(rsp_valid), '0);
    chk("rsp_result_held", rsp_result, RW'(30));
    issue(0, 1000, 24, 1'b0, 1'b1, RW'(1024));
    drain();

    issue(0, 1, 1, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_busy", RW'(busy), '0);
    chk("midrst_rsp_valid", RW'(rsp_valid), '0);
    chk("midrst_rsp_result", rsp_result, '0);
    @(posedge clk); #1;
    resetn = 1'b1;
    eg.push_back(2'b01); ev.push_back(2'b01); er.push_back(RW'(4));
    base = n_ready;
    @(posedge clk); #1;
    req_a[0 +: W] = W'(2);
    req_b[0 +: W] = W'(2);
    req_subtract[0] = 1'b0;
    req_a[W +: W] = W'(9);
    req_b[W +: W] = W'(9);
    req_subtract[1] = 1'b0;
    req = 2'b11;
    wait_ready(base + 1);
    @(posedge clk); #1;
    req = 2'b00;
    drain();

`ifdef MPADDER_ARB_TIMEOUT_EN
    stub = 1'b1;
    issue(1, 9, 9, 1'b0, 1'b1, '0);
    drain();
    chk("timeout_err_set", RW'(timeout_err), RW'(1));
    chk("timeout_idle", RW'(busy), '0);
    stub = 1'b0;
    issue(0, 6, 6, 1'b0, 1'b1, RW'(12));
    drain();
    chk("timeout_err_sticky", RW'(timeout_err), RW'(1));
`else
    chk("timeout_err_off", RW'(timeout_err), '0);
`endif

    chk("sb_grants_empty", RW'(eg.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench watchdog expired");
  end

endmodule
